ddr4_ca_lane_dly_ctrl: RTL

Per-lane delay-line controller for the DDR4 command/address output IODs; sits directly upstream of each address/command lane IOD on FAB_CLK.
- Accepts load, increment, decrement and set-absolute tap commands from the training sequencer.
- Sequences the IOD DELAY_LINE_LOAD/MOVE/DIRECTION controls with enforced pulse spacing.
- Tracks the current tap and reports out-of-range aborts.

---
 rtl/ddr4_ca_pkg.sv | 19 +
 rtl/ddr4_oor_sync.sv | 25 ++
 rtl/ddr4_ca_lane_dly_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/ddr4_ca_pkg.sv
// Shared types and constants for the DDR4 command/address lane delay-line controller.
package ddr4_ca_pkg;

    localparam int unsigned TAP_W = 8;

    localparam logic [1:0] CA_OP_LOAD = 2'b00;
    localparam logic [1:0] CA_OP_INC  = 2'b01;
    localparam logic [1:0] CA_OP_DEC  = 2'b10;
    localparam logic [1:0] CA_OP_SET  = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StPulse,
        StGap,
        StFin
    } ca_state_e;

endpackage

// File: rtl/ddr4_oor_sync.sv
// Two-flop synchronizer for the IOD out-of-range flag; only used when
// DDR4_CA_DLY_OOR_SYNC_EN is defined.
module ddr4_oor_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/ddr4_ca_lane_dly_ctrl.sv
// Per-lane CA delay-line controller: turns tap commands into spaced MOVE/LOAD pulses.
// Define DDR4_CA_DLY_OOR_SYNC_EN to synchronize the OOR flag (gap then forced to >= 3).
module ddr4_ca_lane_dly_ctrl
    import ddr4_ca_pkg::*;
#(
    parameter int unsigned NUM_TAPS = 128,
    parameter int unsigned INIT_TAP = 1,
    parameter int unsigned MOVE_GAP = 4
) (
    input  logic             fab_clk,
    input  logic             sync_rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [TAP_W-1:0] cmd_count,
    output logic             done,
    output logic             err,
    output logic [TAP_W-1:0] tap_value,
    output logic             delay_line_move_0,
    output logic             delay_line_direction_0,
    output logic             delay_line_load_0,
    input  logic             delay_line_out_of_range_0
);

`ifdef DDR4_CA_DLY_OOR_SYNC_EN
    localparam int unsigned EffGap = (MOVE_GAP < 3) ? 3 : MOVE_GAP;
`else
    localparam int unsigned EffGap = MOVE_GAP;
`endif

    localparam logic [TAP_W-1:0] TapMax  = TAP_W'(NUM_TAPS - 1);
    localparam logic [TAP_W-1:0] TapInit = TAP_W'(INIT_TAP);
    localparam logic [3:0]       GapLast = 4'(EffGap - 1);

    ca_state_e        state_q;
    logic [1:0]       op_q;
    logic [TAP_W-1:0] n_q;
    logic [TAP_W-1:0] tap_q;
    logic [3:0]       gap_q;
    logic             ready_q;
    logic             move_q;
    logic             load_q;
    logic             dir_q;
    logic             done_q;
    logic             err_q;
    logic             err_pend_q;
    logic             oor;

    logic [TAP_W-1:0] room;
    logic [TAP_W-1:0] acc_n;
    logic             acc_dir;
    logic             acc_err;

`ifdef DDR4_CA_DLY_OOR_SYNC_EN
    ddr4_oor_sync u_oor_sync (
        .clk      (fab_clk),
        .rst      (sync_rst),
        .async_in (delay_line_out_of_range_0),
        .sync_out (oor)
    );
`else
    assign oor = delay_line_out_of_range_0;
`endif

    // Pulse count, direction and clip error for the command currently offered.
    always_comb begin
        acc_n   = '0;
        acc_dir = 1'b0;
        acc_err = 1'b0;
        room    = TapMax - tap_q;
        case (cmd_op)
            CA_OP_LOAD: acc_n = TAP_W'(1);
            CA_OP_INC: begin
                acc_dir = 1'b1;
                if (cmd_count > room) begin
                    acc_n   = room;
                    acc_err = 1'b1;
                end else begin
                    acc_n = cmd_count;
                end
            end
            CA_OP_DEC: begin
                if (cmd_count > tap_q) begin
                    acc_n   = tap_q;
                    acc_err = 1'b1;
                end else begin
                    acc_n = cmd_count;
                end
            end
            default: begin
                acc_dir = cmd_count > tap_q;
                if (cmd_count > TapMax) begin
                    acc_err = 1'b1;
                end else if (acc_dir) begin
                    acc_n = cmd_count - tap_q;
                end else begin
                    acc_n = tap_q - cmd_count;
                end
            end
        endcase
    end

    always_ff @(posedge fab_clk) begin
        if (sync_rst) begin
            state_q    <= StIdle;
            op_q       <= CA_OP_LOAD;
            n_q        <= '0;
            tap_q      <= TapInit;
            gap_q      <= '0;
            ready_q    <= 1'b1;
            move_q     <= 1'b0;
            load_q     <= 1'b0;
            dir_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_pend_q <= 1'b0;
        end else begin
            // Pulses and DONE are single-cycle; only the entering transition sets them.
            move_q <= 1'b0;
            load_q <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        op_q       <= cmd_op;
                        n_q        <= acc_n;
                        dir_q      <= acc_dir;
                        err_pend_q <= acc_err;
                        err_q      <= 1'b0;
                        ready_q    <= 1'b0;
                        state_q    <= StSetup;
                    end
                end
                StSetup: begin
                    if (n_q == '0) begin
                        done_q  <= 1'b1;
                        err_q   <= err_pend_q;
                        state_q <= StFin;
                    end else begin
                        move_q  <= (op_q != CA_OP_LOAD);
                        load_q  <= (op_q == CA_OP_LOAD);
                        state_q <= StPulse;
                    end
                end
                StPulse: begin
                    n_q     <= n_q - TAP_W'(1);
                    gap_q   <= GapLast;
                    state_q <= StGap;
                    if (op_q == CA_OP_LOAD) begin
                        tap_q <= TapInit;
                    end else if (dir_q) begin
                        tap_q <= tap_q + TAP_W'(1);
                    end else begin
                        tap_q <= tap_q - TAP_W'(1);
                    end
                end
                StGap: begin
                    if (gap_q != '0) begin
                        gap_q <= gap_q - 4'd1;
                    end else if (oor) begin
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= StFin;
                    end else if (n_q != '0) begin
                        move_q  <= (op_q != CA_OP_LOAD);
                        load_q  <= (op_q == CA_OP_LOAD);
                        state_q <= StPulse;
                    end else begin
                        done_q  <= 1'b1;
                        err_q   <= err_pend_q;
                        state_q <= StFin;
                    end
                end
                StFin: begin
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Gated by reset so a command presented alongside reset is never accepted.
    assign cmd_ready              = ready_q & ~sync_rst;
    assign done                   = done_q;
    assign err                    = err_q;
    assign tap_value              = tap_q;
    assign delay_line_move_0      = move_q;
    assign delay_line_load_0      = load_q;
    assign delay_line_direction_0 = dir_q;

endmodule
